// File: rtl/serv_alu_wide.sv
// serv_alu_wide: W-bit-per-beat ALU with its own beat counter, carry, equality and compare state.
// Optional signed-overflow output o_ovf is enabled by defining SERV_ALU_WIDE_OVF_EN.
module serv_alu_wide #(
  parameter int unsigned W    = 4,
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_en,
  input  logic         i_sub,
  input  logic [1:0]   i_bool_op,
  input  logic         i_cmp_eq,
  input  logic         i_cmp_sig,
  input  logic [2:0]   i_rd_sel,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_op_b,
  input  logic [W-1:0] i_buf,
  output logic [W-1:0] o_rd,
  output logic         o_cmp,
  output logic         o_busy,
  output logic         o_done
`ifdef SERV_ALU_WIDE_OVF_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int unsigned N  = XLEN / W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32) || (XLEN % W) != 0)
  begin : g_bad_w
    $error("serv_alu_wide: unsupported W/XLEN combination");
  end

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          cy_r;
  logic          eq_r;
  logic          cmp_r;

  logic          beat0;
  logic          last;
  logic          step;
  logic          cin;
  logic          cout;
  logic          sum_zero;
  logic          lt;
  logic [W-1:0]  add_b;
  logic [W-1:0]  sum;
  logic [W-1:0]  bool_res;
  logic [W-1:0]  slt_res;

  assign beat0 = (state == IDLE) && i_start && i_en;
  assign step  = beat0 || ((state == RUN) && i_en);

  if (N == 1) begin : g_single
    assign last = beat0;
  end else begin : g_multi
    assign last = (state == RUN) && i_en && (cnt == CW'(N - 1));
  end

  assign add_b          = i_op_b ^ {W{i_sub}};
  assign cin            = beat0 ? i_sub : cy_r;
  assign {cout, sum}    = {1'b0, i_rs1} + {1'b0, add_b} + {{W{1'b0}}, cin};
  assign sum_zero       = (sum == '0);
  // Sign extension is taken from the un-inverted operand b, hence the ~ on its term.
  assign lt             = (i_rs1[W-1] & i_cmp_sig) ^ ~(i_op_b[W-1] & i_cmp_sig) ^ cout;
  assign bool_res       = ((i_rs1 ^ i_op_b) & {W{~i_bool_op[0]}})
                        | ({W{i_bool_op[1]}} & i_rs1 & i_op_b);

  always_comb begin
    slt_res    = '0;
    slt_res[0] = cmp_r & beat0;
  end

  assign o_rd   = i_buf
                | ({W{i_rd_sel[0]}} & sum)
                | ({W{i_rd_sel[1]}} & slt_res)
                | ({W{i_rd_sel[2]}} & bool_res);
  assign o_cmp  = cmp_r;
  assign o_busy = (state == RUN);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cy_r   <= 1'b0;
      eq_r   <= 1'b0;
      cmp_r  <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= last;
      if (step) begin
        cy_r <= cout;
        eq_r <= sum_zero & (beat0 | eq_r);
      end
      if (last) begin
        cmp_r <= i_cmp_eq ? (sum_zero & (beat0 | eq_r)) : lt;
        state <= IDLE;
        cnt   <= '0;
      end else if (beat0) begin
        state <= RUN;
        cnt   <= CW'(1);
      end else if (step) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SERV_ALU_WIDE_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two addends.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf <= 1'b0;
    end else if (last) begin
      o_ovf <= cout ^ (sum[W-1] ^ i_rs1[W-1] ^ add_b[W-1]);
    end
  end
`endif

endmodule
